led_mode_sequencer: RTL and testbench

Downstream LED driver stage for the 12 MHz board clock. It replaces the bare counter-MSB blink with a button-selectable pattern engine driving the four red LEDs and the green LED. Internally it has a clock prescaler, a pushbutton synchronizer/debouncer, a four-state mode FSM and an 8-bit PWM generator. It sits directly on the board pins: CLK_IN and a raw button in, the five LED pins out.

---
 rtl/led_mode_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_led_mode_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_mode_sequencer
// Purpose  : Button-selectable LED pattern engine (off / chase / breathe / on).
// Revision : 1.0  initial release
// ============================================================================
module led_mode_sequencer #(
  parameter int TICK_DIV       = 12000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int STEP_TICKS     = 250
) (
  input  logic       CLK_IN,
  input  logic       RST_N,
  input  logic       BTN_N,
  output logic       RLED1,
  output logic       RLED2,
  output logic       RLED3,
  output logic       RLED4,
  output logic       GLED5,
  output logic [1:0] MODE
);

  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_TICKS + 1);
  localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    CHASE   = 2'd1,
    BREATHE = 2'd2,
    ALL_ON  = 2'd3
  } mode_t;

  mode_t             state;
  mode_t             state_next;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic              sync1;
  logic              sync2;
  logic              btn_stable;
  logic              btn_prev;
  logic              press;
  logic [DEB_W-1:0]  deb_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [1:0]        pos;
  logic [7:0]        duty;
  logic [7:0]        pwm_cnt;
  logic              dir_up;
  logic              pwm_on;
  logic [3:0]        red_next;
  logic              green_next;

  assign tick   = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign press  = btn_prev & ~btn_stable;
  assign pwm_on = (pwm_cnt < duty);
  assign MODE   = state;

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // A new level is accepted only after persisting for DEBOUNCE_TICKS ticks in a row.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      btn_stable <= 1'b1;
      btn_prev   <= 1'b1;
      deb_cnt    <= '0;
    end else begin
      sync1    <= BTN_N;
      sync2    <= sync1;
      btn_prev <= btn_stable;
      if (tick) begin
        if (sync2 != btn_stable) begin
          if (deb_cnt == DEB_W'(DEBOUNCE_TICKS - 1)) begin
            btn_stable <= sync2;
            deb_cnt    <= '0;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end else begin
          deb_cnt <= '0;
        end
      end
    end
  end

  // A press reinitialises the pattern state and takes priority over a coincident tick.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      step_cnt <= '0;
      pos      <= '0;
      duty     <= '0;
      dir_up   <= 1'b1;
    end else if (press) begin
      step_cnt <= '0;
      pos      <= '0;
      duty     <= '0;
      dir_up   <= 1'b1;
    end else if (tick) begin
      if (state == CHASE) begin
        if (step_cnt == STEP_W'(STEP_TICKS - 1)) begin
          step_cnt <= '0;
          pos      <= pos + 2'd1;
        end else begin
          step_cnt <= step_cnt + STEP_W'(1);
        end
      end
      if (state == BREATHE) begin
        if (dir_up) begin
          if (duty == 8'hFF) begin
            dir_up <= 1'b0;
            duty   <= 8'hFE;
          end else begin
            duty <= duty + 8'd1;
          end
        end else begin
          if (duty == 8'h00) begin
            dir_up <= 1'b1;
            duty   <= 8'h01;
          end else begin
            duty <= duty - 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state <= CHASE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    red_next   = 4'b0000;
    green_next = 1'b0;
    case (state)
      OFF: begin
        if (press) state_next = CHASE;
      end
      CHASE: begin
        red_next[pos] = 1'b1;
        if (press) state_next = BREATHE;
      end
      BREATHE: begin
        red_next   = {4{pwm_on}};
        green_next = pwm_on;
        if (press) state_next = ALL_ON;
      end
      ALL_ON: begin
        red_next   = 4'b1111;
        green_next = 1'b1;
        if (press) state_next = OFF;
      end
      default: state_next = CHASE;
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      RLED1 <= 1'b0;
      RLED2 <= 1'b0;
      RLED3 <= 1'b0;
      RLED4 <= 1'b0;
      GLED5 <= 1'b0;
    end else begin
      RLED1 <= red_next[0];
      RLED2 <= red_next[1];
      RLED3 <= red_next[2];
      RLED4 <= red_next[3];
      GLED5 <= green_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_mode_sequencer
// Purpose  : Self-checking bench for led_mode_sequencer against a pattern model.
// Revision : 1.0  initial release
// ============================================================================
module tb_led_mode_sequencer;

  localparam int TICK_DIV       = 4;
  localparam int DEBOUNCE_TICKS = 3;
  localparam int STEP_TICKS     = 2;

  logic       clk;
  logic       rst_n;
  logic       btn_n;
  logic       rled1, rled2, rled3, rled4, gled5;
  logic [1:0] mode;

  led_mode_sequencer #(
    .TICK_DIV      (TICK_DIV),
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .STEP_TICKS    (STEP_TICKS)
  ) dut (
    .CLK_IN(clk),
    .RST_N (rst_n),
    .BTN_N (btn_n),
    .RLED1 (rled1),
    .RLED2 (rled2),
    .RLED3 (rled3),
    .RLED4 (rled4),
    .GLED5 (gled5),
    .MODE  (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: elapsed cycles, sync pipeline, accepted level, ticks spent in each mode.
  int         m_cyc;
  int         m_run;
  int         m_chase_ticks;
  int         m_breathe_ticks;
  logic       m_s1, m_s2, m_stable, m_prev;
  logic [1:0] m_mode;
  logic [4:0] exp_leds;
  logic [1:0] exp_mode;
  logic       m_valid;

  function automatic int triangle(input int n);
    int k;
    k = n % 510;
    return (k <= 255) ? k : 510 - k;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    logic tick, press;
    int   pos, duty;
    if (!rst_n) begin
      m_cyc = 0; m_run = 0; m_chase_ticks = 0; m_breathe_ticks = 0;
      m_s1 = 1'b1; m_s2 = 1'b1; m_stable = 1'b1; m_prev = 1'b1;
      m_mode = 2'd1; m_valid = 1'b0;
      return;
    end
    tick  = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
    press = m_prev && !m_stable;
    pos   = (m_chase_ticks / STEP_TICKS) % 4;
    duty  = triangle(m_breathe_ticks);
    case (m_mode)
      2'd0:    exp_leds = 5'b00000;
      2'd1:    exp_leds = 5'b10000 >> pos;
      2'd2:    exp_leds = ((m_cyc % 256) < duty) ? 5'b11111 : 5'b00000;
      default: exp_leds = 5'b11111;
    endcase
    if (press) begin
      m_mode = m_mode + 2'd1;
      m_chase_ticks = 0;
      m_breathe_ticks = 0;
    end else if (tick) begin
      if (m_mode == 2'd1) m_chase_ticks++;
      if (m_mode == 2'd2) m_breathe_ticks++;
    end
    m_prev = m_stable;
    if (tick) begin
      m_run = (m_s2 != m_stable) ? m_run + 1 : 0;
      if (m_run == DEBOUNCE_TICKS) begin
        m_stable = m_s2;
        m_run = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_n;
    m_cyc++;
    exp_mode = m_mode;
    m_valid  = 1'b1;
  endtask

  initial begin
    m_valid = 1'b0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_valid) begin
        check("leds", {3'b0, rled1, rled2, rled3, rled4, gled5}, {3'b0, exp_leds});
        check("mode", {6'b0, mode}, {6'b0, exp_mode});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic press_clean();
    btn_n = 1'b0;
    cycles(30);
    btn_n = 1'b1;
    cycles(30);
  endtask

  function automatic logic [7:0] obs();
    return {1'b0, rled1, rled2, rled3, rled4, gled5, mode};
  endfunction

  initial begin
    rst_n = 1'b0;
    btn_n = 1'b1;
    cycles(3);
    check("reset_state", obs(), {1'b0, 5'b00000, 2'd1});
    rst_n = 1'b1;
    cycles(1);
    check("first_rled1", obs(), {1'b0, 5'b10000, 2'd1});
    cycles(8);
    check("chase_rled2", obs(), {1'b0, 5'b01000, 2'd1});
    cycles(8);
    check("chase_rled3", obs(), {1'b0, 5'b00100, 2'd1});
    cycles(8);
    check("chase_rled4", obs(), {1'b0, 5'b00010, 2'd1});
    cycles(8);
    check("chase_wrap", obs(), {1'b0, 5'b10000, 2'd1});

    cycles(5);
    rst_n = 1'b0;
    #1;
    check("async_reset", obs(), {1'b0, 5'b00000, 2'd1});
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    check("rerelease_rled1", obs(), {1'b0, 5'b10000, 2'd1});

    btn_n = 1'b0;
    cycles(8);
    btn_n = 1'b1;
    cycles(20);
    check("short_glitch", {6'b0, mode}, 8'd1);

    btn_n = 1'b0;
    cycles(1000);
    check("held_one_step", {6'b0, mode}, 8'd2);
    btn_n = 1'b1;
    cycles(30);
    check("held_release", {6'b0, mode}, 8'd2);

    press_clean();
    check("wrap_all_on", obs(), {1'b0, 5'b11111, 2'd3});
    press_clean();
    check("wrap_off", obs(), {1'b0, 5'b00000, 2'd0});
    btn_n = 1'b0;
    cycles(20);
    check("reentry_chase", obs(), {1'b0, 5'b10000, 2'd1});
    cycles(10);
    btn_n = 1'b1;
    cycles(30);
    press_clean();
    check("breathe_entry", {6'b0, mode}, 8'd2);

    cycles(2200);

    for (int i = 0; i < 67; i++) begin
      btn_n = ~btn_n;
      cycles(3);
    end
    btn_n = 1'b1;
    cycles(20);
    check("glitch_train", {6'b0, mode}, 8'd2);

    for (int i = 0; i < 60; i++) begin
      btn_n = 1'($urandom_range(0, 1));
      cycles(int'($urandom_range(1, 60)));
      if ($urandom_range(0, 19) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        check("rand_reset", obs(), {1'b0, 5'b00000, 2'd1});
        cycles(2);
        rst_n = 1'b1;
      end
    end
    btn_n = 1'b1;
    cycles(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
